// File: rtl/uart_fifo_bridge_pkg.sv
// Shared definitions for the UART FIFO bridge: status/control bit positions,
// FSM state types and the RX-count saturation helper.
package uart_fifo_bridge_pkg;

  localparam int unsigned ST_RX_NONEMPTY = 0;
  localparam int unsigned ST_TX_FULL     = 1;
  localparam int unsigned ST_TX_EMPTY    = 2;
  localparam int unsigned ST_TX_OVF      = 3;
  localparam int unsigned ST_RX_EN       = 4;
  localparam int unsigned ST_TXE_EN      = 5;
  localparam int unsigned ST_CNT_LSB     = 8;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_STROBE = 2'd1,
    TX_GUARD  = 2'd2
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_ACK   = 2'd1,
    RX_GUARD = 2'd2
  } rx_state_e;

  function automatic logic [7:0] sat8(input int unsigned v);
    return (v > 32'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/uart_fifo_bridge_sync_fifo.sv
// Register-array FIFO with head-of-queue output, occupancy count and full/empty flags.
// Push while full and pop while empty are ignored; push and pop together both apply.
module sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// IO-bus peripheral bridging the J1 io_rd/io_wr bus to a byte UART core,
// with TX/RX FIFOs, status/control register, paced TX, RX backpressure and a level irq.
module uart_fifo_bridge
  import uart_fifo_bridge_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 16,
  parameter int unsigned DATA_BIT = 12,
  parameter int unsigned STAT_BIT = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_rd,
  input  logic              io_wr,
  input  logic [15:0]       io_addr,
  input  logic [15:0]       io_dout,
  output logic [15:0]       io_din,
  output logic              uart_wr,
  output logic [DATA_W-1:0] uart_w,
  input  logic              uart_busy,
  output logic              uart_rd,
  input  logic              uart_valid,
  input  logic [DATA_W-1:0] uart_data,
  output logic              irq
);

  logic                        data_sel, stat_sel;
  logic                        tx_push, tx_pop, tx_full, tx_empty;
  logic                        rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_W-1:0]           tx_head, rx_head;
  logic [$clog2(TX_DEPTH):0]   tx_count;
  logic [$clog2(RX_DEPTH):0]   rx_count;
  logic [15:0]                 status;

  tx_state_e                   tx_state_q, tx_state_d;
  rx_state_e                   rx_state_q, rx_state_d;
  logic [DATA_W-1:0]           uart_w_q, uart_w_d;
  logic                        tx_ovf_q, tx_ovf_d;
  logic [1:0]                  irq_en_q, irq_en_d;
  logic                        irq_q, irq_d;
  logic                        unused_bus;

  // Data select wins when both address bits are set.
  assign data_sel = io_addr[DATA_BIT];
  assign stat_sel = io_addr[STAT_BIT] & ~io_addr[DATA_BIT];

  assign tx_push = io_wr & data_sel & ~tx_full;
  assign rx_pop  = io_rd & data_sel & ~rx_empty;

  assign unused_bus = ^{io_addr, io_dout, tx_count};

  sync_fifo #(
    .W     (DATA_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .din_i   (io_dout[DATA_W-1:0]),
    .head_o  (tx_head),
    .count_o (tx_count),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  sync_fifo #(
    .W     (DATA_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .din_i   (uart_data),
    .head_o  (rx_head),
    .count_o (rx_count),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  always_comb begin
    status                         = '0;
    status[ST_RX_NONEMPTY]         = ~rx_empty;
    status[ST_TX_FULL]             = tx_full;
    status[ST_TX_EMPTY]            = tx_empty;
    status[ST_TX_OVF]              = tx_ovf_q;
    status[ST_TXE_EN:ST_RX_EN]     = irq_en_q;
    status[15:ST_CNT_LSB]          = sat8(32'(rx_count));
  end

  always_comb begin
    io_din = '0;
    if (data_sel) begin
      if (!rx_empty) io_din[DATA_W-1:0] = rx_head;
    end else if (stat_sel) begin
      io_din = status;
    end
  end

  // Overflow is judged on the full flag at start of cycle, so a same-cycle pop does not save the write.
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    irq_en_d = irq_en_q;
    if (io_wr && data_sel && tx_full) begin
      tx_ovf_d = 1'b1;
    end else if (io_wr && stat_sel) begin
      if (io_dout[ST_TX_OVF]) tx_ovf_d = 1'b0;
      irq_en_d = io_dout[ST_TXE_EN:ST_RX_EN];
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    uart_w_d   = uart_w_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty && !uart_busy) begin
          uart_w_d   = tx_head;
          tx_pop     = 1'b1;
          tx_state_d = TX_STROBE;
        end
      end
      TX_STROBE: tx_state_d = TX_GUARD;
      TX_GUARD:  tx_state_d = TX_IDLE;
      default:   tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (uart_valid && !rx_full) begin
          rx_push    = 1'b1;
          rx_state_d = RX_ACK;
        end
      end
      RX_ACK:   rx_state_d = RX_GUARD;
      RX_GUARD: rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    irq_d = (irq_en_q[0] & ~rx_empty) | (irq_en_q[1] & tx_empty);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      rx_state_q <= RX_IDLE;
      uart_w_q   <= '0;
      tx_ovf_q   <= 1'b0;
      irq_en_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      uart_w_q   <= uart_w_d;
      tx_ovf_q   <= tx_ovf_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
    end
  end

  // Strobes decode directly from state flops so reset drops them without waiting for a clock.
  assign uart_wr = (tx_state_q == TX_STROBE);
  assign uart_rd = (rx_state_q == RX_ACK);
  assign uart_w  = uart_w_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge with a simple UART model on both sides.
module tb_uart_fifo_bridge;

  localparam logic [15:0] A_DATA = 16'h1000;
  localparam logic [15:0] A_STAT = 16'h2000;
  localparam logic [15:0] A_BOTH = 16'h3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_rd, io_wr;
  logic [15:0] io_addr, io_dout, io_din;
  logic        uart_wr;
  logic [7:0]  uart_w;
  logic        uart_busy;
  logic        uart_rd;
  logic        uart_valid;
  logic [7:0]  uart_data;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  src_mem [64];
  logic [5:0]  src_wr = '0;
  logic [5:0]  src_rd = '0;
  logic [7:0]  tx_log [64];
  int unsigned tx_cnt   = 0;
  int unsigned rd_cnt   = 0;
  int unsigned cyc      = 0;
  int unsigned last_cyc = 0;
  int unsigned min_gap  = 1000;

  logic [15:0] rdata;
  logic        seen;

  always #5 clk = ~clk;

  assign uart_valid = (src_rd != src_wr);
  assign uart_data  = src_mem[src_rd];

  uart_fifo_bridge #(
    .DATA_W   (8),
    .TX_DEPTH (16),
    .RX_DEPTH (16),
    .DATA_BIT (12),
    .STAT_BIT (13)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .io_rd      (io_rd),
    .io_wr      (io_wr),
    .io_addr    (io_addr),
    .io_dout    (io_dout),
    .io_din     (io_din),
    .uart_wr    (uart_wr),
    .uart_w     (uart_w),
    .uart_busy  (uart_busy),
    .uart_rd    (uart_rd),
    .uart_valid (uart_valid),
    .uart_data  (uart_data),
    .irq        (irq)
  );

  // UART model: logs transmitted chars and advances the RX source on each ack.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (uart_wr) begin
      tx_log[tx_cnt[5:0]] <= uart_w;
      tx_cnt <= tx_cnt + 1;
      if (tx_cnt != 0 && (cyc - last_cyc) < min_gap) min_gap <= cyc - last_cyc;
      last_cyc <= cyc;
    end
    if (uart_rd) begin
      src_rd <= src_rd + 6'd1;
      rd_cnt <= rd_cnt + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clk);
    io_addr = addr;
    io_dout = data;
    io_wr   = 1'b1;
    @(negedge clk);
    io_wr   = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [15:0] data);
    @(negedge clk);
    io_addr = addr;
    io_rd   = 1'b1;
    #1 data = io_din;
    @(negedge clk);
    io_rd   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; io_rd = 1'b0; io_wr = 1'b0; io_addr = '0; io_dout = '0; uart_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_uart_wr", {31'd0, uart_wr}, 32'd0);
    chk("rst_uart_rd", {31'd0, uart_rd}, 32'd0);
    chk("rst_uart_w",  {24'd0, uart_w},  32'd0);
    chk("rst_irq",     {31'd0, irq},     32'd0);
    reset = 1'b0;

    // 1: idle status and empty data read
    bus_read(A_STAT, rdata); chk("t1_status", {16'd0, rdata}, 32'h0004);
    bus_read(A_DATA, rdata); chk("t1_data_empty", {16'd0, rdata}, 32'h0000);
    bus_read(A_STAT, rdata); chk("t1_status_after", {16'd0, rdata}, 32'h0004);

    // 2: three chars paced out, then a write with both address bits set
    bus_write(A_DATA, 16'h0041);
    bus_write(A_DATA, 16'h0042);
    bus_write(A_DATA, 16'h0043);
    repeat (15) @(negedge clk);
    chk("t2_tx_cnt", tx_cnt, 32'd3);
    chk("t2_char0", {24'd0, tx_log[0]}, 32'h41);
    chk("t2_char1", {24'd0, tx_log[1]}, 32'h42);
    chk("t2_char2", {24'd0, tx_log[2]}, 32'h43);
    chk("t2_min_gap_ge3", {31'd0, min_gap >= 3}, 32'd1);
    bus_read(A_STAT, rdata); chk("t2_status", {16'd0, rdata}, 32'h0004);
    bus_write(A_BOTH, 16'h005A);
    repeat (10) @(negedge clk);
    chk("t2_prio_cnt", tx_cnt, 32'd4);
    chk("t2_prio_char", {24'd0, tx_log[3]}, 32'h5A);
    bus_read(A_STAT, rdata); chk("t2_prio_status", {16'd0, rdata}, 32'h0004);

    // 3: overflow with busy held, clear ovf, then drain
    uart_busy = 1'b1;
    for (int i = 0; i < 17; i++) bus_write(A_DATA, 16'(16'h0060 + i));
    bus_read(A_STAT, rdata); chk("t3_full_ovf", {16'd0, rdata}, 32'h000A);
    chk("t3_no_tx_busy", tx_cnt, 32'd4);
    bus_write(A_STAT, 16'h0008);
    bus_read(A_STAT, rdata); chk("t3_ovf_clr", {16'd0, rdata}, 32'h0002);
    uart_busy = 1'b0;
    repeat (60) @(negedge clk);
    chk("t3_tx_cnt", tx_cnt, 32'd20);
    chk("t3_first", {24'd0, tx_log[4]}, 32'h60);
    chk("t3_last", {24'd0, tx_log[19]}, 32'h6F);
    chk("t3_min_gap", min_gap, 32'd3);
    bus_read(A_STAT, rdata); chk("t3_status", {16'd0, rdata}, 32'h0004);

    // 4: two received chars
    src_mem[0] = 8'h55; src_mem[1] = 8'hAA; src_wr = 6'd2;
    repeat (12) @(negedge clk);
    chk("t4_rd_cnt", rd_cnt, 32'd2);
    bus_read(A_STAT, rdata); chk("t4_status", {16'd0, rdata}, 32'h0205);
    bus_read(A_DATA, rdata); chk("t4_data0", {16'd0, rdata}, 32'h0055);
    bus_read(A_DATA, rdata); chk("t4_data1", {16'd0, rdata}, 32'h00AA);
    bus_read(A_STAT, rdata); chk("t4_status_end", {16'd0, rdata}, 32'h0004);

    // 5: RX backpressure
    for (int i = 0; i < 17; i++) src_mem[2+i] = 8'(8'h80 + i);
    src_wr = 6'd19;
    repeat (70) @(negedge clk);
    chk("t5_rd_cnt16", rd_cnt, 32'd18);
    bus_read(A_STAT, rdata); chk("t5_status_full", {16'd0, rdata}, 32'h1005);
    repeat (10) @(negedge clk);
    chk("t5_no_17th", rd_cnt, 32'd18);
    chk("t5_valid_held", {31'd0, uart_valid}, 32'd1);
    bus_read(A_DATA, rdata); chk("t5_pop", {16'd0, rdata}, 32'h0080);
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (uart_rd) seen = 1'b1;
    end
    chk("t5_refill_ack", {31'd0, seen}, 32'd1);
    repeat (4) @(negedge clk);
    bus_read(A_STAT, rdata); chk("t5_status_refill", {16'd0, rdata}, 32'h1005);
    chk("t5_rd_cnt17", rd_cnt, 32'd19);
    for (int i = 0; i < 16; i++) begin
      bus_read(A_DATA, rdata);
      chk("t5_drain", {16'd0, rdata}, 32'(32'h81 + i));
    end
    bus_read(A_STAT, rdata); chk("t5_status_end", {16'd0, rdata}, 32'h0004);

    // 6: interrupts and reset during a TX strobe
    bus_write(A_STAT, 16'h0010);
    bus_read(A_STAT, rdata); chk("t6_en_status", {16'd0, rdata}, 32'h0014);
    chk("t6_irq_idle", {31'd0, irq}, 32'd0);
    @(negedge clk);
    src_mem[19] = 8'hC3; src_wr = 6'd20;
    @(negedge clk);
    chk("t6_irq_push_edge", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("t6_irq_set", {31'd0, irq}, 32'd1);
    bus_read(A_DATA, rdata); chk("t6_pop", {16'd0, rdata}, 32'h00C3);
    chk("t6_irq_hold", {31'd0, irq}, 32'd1);
    @(negedge clk);
    chk("t6_irq_clr", {31'd0, irq}, 32'd0);
    bus_write(A_STAT, 16'h0020);
    @(negedge clk);
    chk("t6_txe_irq", {31'd0, irq}, 32'd1);
    bus_write(A_STAT, 16'h0000);
    @(negedge clk);
    chk("t6_irq_off", {31'd0, irq}, 32'd0);

    bus_write(A_DATA, 16'h0077);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (uart_wr) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t6_strobe_seen", {31'd0, seen}, 32'd1);
    chk("t6_strobe_char", {24'd0, uart_w}, 32'h77);
    reset = 1'b1;
    #1;
    chk("t6_rst_uart_wr", {31'd0, uart_wr}, 32'd0);
    chk("t6_rst_uart_w", {24'd0, uart_w}, 32'd0);
    chk("t6_rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus_read(A_STAT, rdata); chk("t6_rst_status", {16'd0, rdata}, 32'h0004);
    repeat (5) @(negedge clk);
    chk("t6_no_tx_after_rst", tx_cnt, 32'd20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
